prim_ram_1p_cfg_ctrl: RTL and testbench

Upstream producer of `ram_1p_cfg_t` for a group of single-port RAM instances. Software stages a new RAM/regfile configuration, then commits it. The block quiesces all attached RAMs (stall, then wait for idle), swaps the configuration atomically, holds a settle window and releases. It sits between the CSR block and the `prim_ram_1p` instances' `cfg_i` inputs.

---
 rtl/prim_ram_1p_pkg.sv | 29 ++
 rtl/prim_ram_1p_cfg_timer.sv | 37 +++
 rtl/prim_ram_1p_cfg_ctrl.sv | 156 +++++++++++++++
 tb/tb_prim_ram_1p_cfg_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prim_ram_1p_pkg.sv
// Shared types for the single-port RAM primitive: the per-instance config
// word and the state encoding of the config-update controller.
package prim_ram_1p_pkg;

  typedef struct packed {
    logic       en;
    logic [3:0] val;
  } ram_cfg_t;

  typedef struct packed {
    logic       en;
    logic [3:0] val;
  } rf_cfg_t;

  typedef struct packed {
    ram_cfg_t ram_cfg;
    rf_cfg_t  rf_cfg;
  } ram_1p_cfg_t;

  localparam ram_1p_cfg_t RAM_1P_CFG_DEFAULT = '0;

  typedef enum logic [1:0] {
    CfgIdle   = 2'd0,
    CfgDrain  = 2'd1,
    CfgApply  = 2'd2,
    CfgSettle = 2'd3
  } ram_cfg_ctrl_state_e;

endpackage

// File: rtl/prim_ram_1p_cfg_timer.sv
// Loadable saturating down-counter; expired_o is high while the count is zero.
module prim_ram_1p_cfg_timer #(
  parameter int Max = 64,
  localparam int W  = $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/prim_ram_1p_cfg_ctrl.sv
// Stages a RAM/regfile config, quiesces the attached RAMs, swaps the config
// atomically and holds stall through a settle window before releasing.
module prim_ram_1p_cfg_ctrl
  import prim_ram_1p_pkg::*;
#(
  parameter int NumRams      = 4,
  parameter int DrainTimeout = 64,
  parameter int SettleCycles = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cfg_we_i,
  input  ram_1p_cfg_t               cfg_wdata_i,
  input  logic                      commit_i,
  input  logic [NumRams-1:0]        ram_idle_i,
  output logic [NumRams-1:0]        ram_stall_o,
  output ram_1p_cfg_t [NumRams-1:0] ram_cfg_o,
  output logic                      staged_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      timeout_o,
  output logic                      wr_err_o
);

  localparam int DrainW  = $clog2(DrainTimeout + 1);
  localparam int SettleW = $clog2(SettleCycles + 1);
  // Loaded with N-1 so the timer expires during the N-th cycle in the state.
  localparam logic [DrainW-1:0]  DrainLoad  = DrainW'(DrainTimeout - 1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SettleCycles - 1);

  ram_cfg_ctrl_state_e state_d, state_q;
  ram_1p_cfg_t         stage_d, stage_q;
  ram_1p_cfg_t         cfg_d, cfg_q;
  logic                staged_d, staged_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;
  logic                timeout_d, timeout_q;
  logic                wr_err_d, wr_err_q;

  logic drain_load, drain_dec, drain_expired;
  logic settle_load, settle_dec, settle_expired;

  prim_ram_1p_cfg_timer #(.Max(DrainTimeout)) u_drain_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (drain_load),
    .load_val_i (DrainLoad),
    .dec_i      (drain_dec),
    .expired_o  (drain_expired)
  );

  prim_ram_1p_cfg_timer #(.Max(SettleCycles)) u_settle_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (settle_load),
    .load_val_i (SettleLoad),
    .dec_i      (settle_dec),
    .expired_o  (settle_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    staged_d    = staged_q;
    cfg_d       = cfg_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    wr_err_d    = 1'b0;
    drain_load  = 1'b0;
    drain_dec   = 1'b0;
    settle_load = 1'b0;
    settle_dec  = 1'b0;

    if (cfg_we_i) begin
      if (state_q == CfgIdle) begin
        stage_d  = cfg_wdata_i;
        staged_d = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end

    unique case (state_q)
      CfgIdle: begin
        if (commit_i && (staged_q || cfg_we_i)) begin
          state_d    = CfgDrain;
          drain_load = 1'b1;
        end
      end
      CfgDrain: begin
        // All-idle takes precedence over a coincident timeout.
        if (&ram_idle_i) begin
          state_d = CfgApply;
        end else if (drain_expired) begin
          state_d   = CfgIdle;
          timeout_d = 1'b1;
        end else begin
          drain_dec = 1'b1;
        end
      end
      CfgApply: begin
        cfg_d       = stage_q;
        staged_d    = 1'b0;
        settle_load = 1'b1;
        state_d     = CfgSettle;
      end
      CfgSettle: begin
        if (settle_expired) begin
          state_d = CfgIdle;
          done_d  = 1'b1;
        end else begin
          settle_dec = 1'b1;
        end
      end
      default: state_d = CfgIdle;
    endcase

    busy_d = (state_d != CfgIdle);
  end

  // NOTE: the staging register is reset along with the rest; a reset must
  // discard any uncommitted config rather than let stale data be applied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CfgIdle;
      stage_q   <= RAM_1P_CFG_DEFAULT;
      cfg_q     <= RAM_1P_CFG_DEFAULT;
      staged_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cfg_q     <= cfg_d;
      staged_q  <= staged_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Stall covers every non-Idle state, so it is identical to busy.
  assign ram_stall_o = {NumRams{busy_q}};
  assign ram_cfg_o   = {NumRams{cfg_q}};
  assign staged_o    = staged_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign wr_err_o    = wr_err_q;

endmodule

// File: tb/tb_prim_ram_1p_cfg_ctrl.sv
// Directed bench for prim_ram_1p_cfg_ctrl: inputs change and outputs are
// sampled on the falling edge; cycle T+k is the k-th cycle after commit edge T.
module tb_prim_ram_1p_cfg_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_we_i;
  logic [9:0]  cfg_wdata_i;
  logic        commit_i;
  logic [3:0]  ram_idle_i;
  logic [3:0]  ram_stall_o;
  logic [39:0] ram_cfg_o;
  logic        staged_o;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic        wr_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  prim_ram_1p_cfg_ctrl #(
    .NumRams      (4),
    .DrainTimeout (64),
    .SettleCycles (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_we_i    (cfg_we_i),
    .cfg_wdata_i (cfg_wdata_i),
    .commit_i    (commit_i),
    .ram_idle_i  (ram_idle_i),
    .ram_stall_o (ram_stall_o),
    .ram_cfg_o   (ram_cfg_o),
    .staged_o    (staged_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .wr_err_o    (wr_err_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  function automatic logic [39:0] rep(input logic [9:0] v);
    return {4{v}};
  endfunction

  task automatic stage(input logic [9:0] v);
    cfg_we_i    = 1'b1;
    cfg_wdata_i = v;
    step(1);
    cfg_we_i    = 1'b0;
  endtask

  // Commit sampled at edge T; returns in cycle T+1.
  task automatic commit_now();
    commit_i = 1'b1;
    step(1);
    commit_i = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_wdata_i = '0;
    commit_i    = 1'b0;
    ram_idle_i  = 4'hF;
    step(2);

    // Reset state
    check("rst_cfg",    ram_cfg_o,   40'h0);
    check("rst_stall",  ram_stall_o, 4'h0);
    check("rst_staged", staged_o,    1'b0);
    check("rst_busy",   busy_o,      1'b0);
    rst_ni = 1'b1;
    step(1);

    // Commit with nothing staged is ignored
    commit_now();
    check("empty_busy",  busy_o, 1'b0);
    check("empty_done",  done_o, 1'b0);
    step(4);
    check("empty_done2", {busy_o, done_o, timeout_o}, 3'b000);

    // Basic commit, all RAMs idle
    stage(10'h2A5);
    check("stage_flag", staged_o, 1'b1);
    commit_now();
    check("t1_stall", ram_stall_o, 4'hF);
    check("t1_busy",  busy_o,      1'b1);
    step(1);
    check("t2_cfg_old", ram_cfg_o, 40'h0);
    step(1);
    check("t3_cfg_new", ram_cfg_o, rep(10'h2A5));
    check("t3_staged",  staged_o,  1'b0);
    check("t3_stall",   ram_stall_o, 4'hF);
    step(1);
    check("t4_done", done_o, 1'b0);
    step(1);
    check("t5_done",  done_o,      1'b1);
    check("t5_stall", ram_stall_o, 4'h0);
    check("t5_busy",  busy_o,      1'b0);
    step(1);
    check("t6_done", done_o, 1'b0);

    // Drain waits for the first all-idle cycle
    stage(10'h155);
    ram_idle_i = 4'b1011;
    commit_now();
    for (int i = 0; i < 9; i++) begin
      step(1);
      check("drain_cfg", ram_cfg_o, rep(10'h2A5));
    end
    check("drain_stall", ram_stall_o, 4'hF);
    ram_idle_i = 4'hF;
    step(1);
    check("drain_apply_cfg", ram_cfg_o, rep(10'h2A5));
    step(1);
    check("drain_new_cfg", ram_cfg_o, rep(10'h155));
    step(2);
    check("drain_done", done_o, 1'b1);

    // Drain timeout
    stage(10'h0F0);
    ram_idle_i = 4'b0111;
    commit_now();
    step(63);
    check("to_t64_busy", busy_o,    1'b1);
    check("to_t64_pls",  timeout_o, 1'b0);
    step(1);
    check("to_pulse",  timeout_o,   1'b1);
    check("to_stall",  ram_stall_o, 4'h0);
    check("to_busy",   busy_o,      1'b0);
    check("to_cfg",    ram_cfg_o,   rep(10'h155));
    check("to_staged", staged_o,    1'b1);
    check("to_done",   done_o,      1'b0);
    step(1);
    check("to_pulse_end", timeout_o, 1'b0);
    ram_idle_i = 4'hF;
    commit_now();
    step(4);
    check("recommit_done", done_o,    1'b1);
    check("recommit_cfg",  ram_cfg_o, rep(10'h0F0));

    // Write during Settle is dropped
    stage(10'h3C3);
    commit_now();
    step(2);
    cfg_we_i    = 1'b1;
    cfg_wdata_i = 10'h1FF;
    step(1);
    cfg_we_i    = 1'b0;
    check("wr_err_pulse", wr_err_o, 1'b1);
    step(1);
    check("wr_err_end",   wr_err_o,  1'b0);
    check("settle_done",  done_o,    1'b1);
    check("settle_cfg",   ram_cfg_o, rep(10'h3C3));
    check("wr_dropped",   staged_o,  1'b0);
    commit_now();
    check("wr_dropped_commit", busy_o, 1'b0);

    // Same-cycle write and commit
    cfg_we_i    = 1'b1;
    cfg_wdata_i = 10'h011;
    commit_i    = 1'b1;
    step(1);
    cfg_we_i    = 1'b0;
    commit_i    = 1'b0;
    check("wc_busy", busy_o, 1'b1);
    step(4);
    check("wc_done", done_o,    1'b1);
    check("wc_cfg",  ram_cfg_o, rep(10'h011));

    // Reset during Drain
    stage(10'h2AA);
    ram_idle_i = 4'h0;
    commit_now();
    step(2);
    rst_ni = 1'b0;
    #1;
    check("rst_drain_cfg",   ram_cfg_o,   40'h0);
    check("rst_drain_stall", ram_stall_o, 4'h0);
    check("rst_drain_busy",  busy_o,      1'b0);
    check("rst_drain_stg",   staged_o,    1'b0);
    step(1);
    rst_ni     = 1'b1;
    ram_idle_i = 4'hF;
    step(1);

    // Reset during Settle
    stage(10'h155);
    commit_now();
    step(2);
    check("pre_rst_cfg", ram_cfg_o, rep(10'h155));
    rst_ni = 1'b0;
    #1;
    check("rst_settle_cfg",   ram_cfg_o,   40'h0);
    check("rst_settle_stall", ram_stall_o, 4'h0);
    check("rst_settle_busy",  busy_o,      1'b0);
    step(1);
    rst_ni = 1'b1;
    step(1);
    commit_now();
    check("post_rst_idle", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
